sqrt_iter: RTL and testbench
============================

SQRT_ITER -- requirements
Module: sqrt_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning radicand width in bits; legal values are even and >= 4.
REQ-002 The block SHALL have parameter ROUND, default 0, meaning 0 = floor root and 1 = round-to-nearest root.
REQ-003 The block SHALL have a port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have a port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have a port x_in, input, WIDTH bits: the unsigned radicand.
REQ-006 The block SHALL have a port x_ready, input, 1 bit: the start request, sampled only in IDLE.
REQ-007 The block SHALL have a port y_out, output reg, WIDTH/2 bits: the root result.
REQ-008 The block SHALL have a port r_out, output reg, WIDTH/2+1 bits: the remainder x - floor_root^2.
REQ-009 The block SHALL have a port y_ready, output reg, 1 bit: a one-cycle result-valid pulse.
REQ-010 The block SHALL have a port busy, output reg, 1 bit: high from the capture edge until the result edge.

Function
REQ-011 The block SHALL implement the states IDLE, CALC and DONE, with a 3-bit state register.
REQ-012 In IDLE, with x_ready=1 at a clock edge, the block SHALL perform all of the following on that edge:
- capture x_in into x;
- load m = 1<<(WIDTH-2) and y = 0;
- load iteration counter = WIDTH/2;
- set busy = 1 and enter CALC.
REQ-013 In CALC, the block SHALL perform exactly one iteration per clock edge:
- if x >= (y|m): x <= x-(y|m) and y <= (y>>1)|m;
- otherwise y <= y>>1;
- then m <= m>>2 and the counter decrements.
REQ-014 The block SHALL move from CALC to DONE on the edge performing the iteration where the counter equals 1, so CALC lasts exactly WIDTH/2 cycles.
REQ-015 In DONE, on the next edge, the block SHALL perform all of the following:
- load y_out and r_out;
- set y_ready = 1 and busy = 0;
- return to IDLE.
REQ-016 The block SHALL deassert y_ready on the following edge, so y_ready is high for exactly one cycle per accepted request.
REQ-017 Latency: the block SHALL present results at edge N+WIDTH/2+1 for a request captured at edge N (5 cycles for WIDTH=8).
REQ-018 y_out and r_out SHALL hold their values until the next result edge, or until reset.
REQ-019 The block SHALL ignore x_ready while in CALC or DONE: requests are not queued and in-flight data is not disturbed.
REQ-020 The block SHALL ignore changes on x_in after the capture edge.
REQ-021 A new request SHALL be accepted at the earliest on the edge after the result edge, i.e. one accepted request per WIDTH/2+2 cycles.
REQ-022 With ROUND=0, y_out SHALL equal floor(sqrt(x)).
REQ-023 With ROUND=1, y_out SHALL equal floor_root+1 when remainder > floor_root, and floor_root otherwise.
REQ-024 With ROUND=1, when floor_root is all ones the increment SHALL saturate at all ones (2^(WIDTH/2)-1).
REQ-025 With ROUND=1, r_out SHALL still report the floor remainder.
REQ-026 r_out SHALL never exceed 2*floor_root, and so SHALL fit in WIDTH/2+1 bits without truncation.
REQ-027 Internal x, y and m registers SHALL be WIDTH bits wide, with no truncation in comparison or subtraction.
REQ-028 The block SHALL terminate in fixed latency for x=0 and for x=2^WIDTH-1, with no data-dependent early exit.

Reset
REQ-029 The block SHALL act on rst=1 immediately, independent of clk.
REQ-030 While rst=1, the block SHALL hold state = IDLE and y_out = 0, r_out = 0, y_ready = 0, busy = 0.
REQ-031 Reset asserted mid-CALC or in DONE SHALL abort the computation with no y_ready pulse.
REQ-032 The first request after reset release SHALL be accepted on the first edge with rst=0 and x_ready=1.

Verification
REQ-033 WIDTH=8, ROUND=0, x_in=0 pulsed -> y_out=0, r_out=0, y_ready pulse 5 edges after capture, busy high for exactly those 5 cycles.
REQ-034 WIDTH=8, ROUND=0, x_in=255 -> y_out=15, r_out=30; and x_in=144 -> y_out=12, r_out=0.
REQ-035 WIDTH=8, ROUND=1: x_in=56 -> y_out=7, r_out=7; x_in=57 -> y_out=8, r_out=8; x_in=255 -> y_out=15 (saturated), r_out=30.
REQ-036 WIDTH=16, ROUND=0: x_in=65535 -> y_out=255, r_out=510 after 9 cycles; an exhaustive sweep of all 65536 inputs against the floor root matches.
REQ-037 WIDTH=8: x_ready held high continuously with x_in changing every cycle -> only the values present on capture edges spaced 6 cycles apart are processed, each with a correct result and a single y_ready pulse.
REQ-038 WIDTH=8: rst pulsed 2 cycles after capture of x_in=200 -> outputs 0, no y_ready; a request with x_in=100 after release -> y_out=10, r_out=0.

Source files
------------

// File: rtl/sqrt_iter_if.sv
// rtl/sqrt_iter_if.sv - request/result bundle for the iterative square-root unit
interface sqrt_iter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   x_in;
  logic               x_ready;
  logic [WIDTH/2-1:0] y_out;
  logic [WIDTH/2:0]   r_out;
  logic               y_ready;
  logic               busy;

  modport master (
    output x_in, x_ready,
    input  y_out, r_out, y_ready, busy
  );

  modport slave (
    input  x_in, x_ready,
    output y_out, r_out, y_ready, busy
  );
endinterface

// File: rtl/sqrt_iter.sv
// rtl/sqrt_iter.sv - fixed-latency digit-by-digit integer square root
module sqrt_iter #(
  parameter int WIDTH = 8,
  parameter int ROUND = 0
) (
  input  logic        clk,
  input  logic        rst,
  sqrt_iter_if.slave  bus
);
  localparam int HW = WIDTH / 2;
  localparam int CW = $clog2(HW + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    DONE = 3'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [HW-1:0]    y_out_q, y_out_d;
  logic [HW:0]      r_out_q, r_out_d;
  logic             y_ready_q, y_ready_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] trial;
  logic [HW-1:0]    root;
  logic [HW:0]      rem;
  logic             round_up;

  always_comb begin
    trial    = y_q | m_q;
    root     = y_q[HW-1:0];
    rem      = x_q[HW:0];
    // Nearest rounding: remainder beyond the root means x is past root+0.5 squared.
    round_up = (ROUND != 0) && (x_q > y_q) && (root != {HW{1'b1}});

    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    y_out_d   = y_out_q;
    r_out_d   = r_out_q;
    y_ready_d = 1'b0;
    busy_d    = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.x_ready) begin
          x_d     = bus.x_in;
          m_d     = WIDTH'(1) << (WIDTH - 2);
          y_d     = '0;
          cnt_d   = CW'(HW);
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (x_q >= trial) begin
          x_d = x_q - trial;
          y_d = (y_q >> 1) | m_q;
        end else begin
          y_d = y_q >> 1;
        end
        m_d   = m_q >> 2;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        y_out_d   = root + HW'(round_up);
        r_out_d   = rem;
        y_ready_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      y_out_q   <= '0;
      r_out_q   <= '0;
      y_ready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      y_out_q   <= y_out_d;
      r_out_q   <= r_out_d;
      y_ready_q <= y_ready_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.y_out   = y_out_q;
  assign bus.r_out   = r_out_q;
  assign bus.y_ready = y_ready_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_sqrt_iter.sv
// tb/tb_sqrt_iter.sv - randomized self-checking bench for sqrt_iter
module tb_sqrt_iter;
  logic clk = 1'b0;
  logic rst;
  logic [7:0]  x8;
  logic        xr8;
  logic [15:0] x16;
  logic        xr16;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sqrt_iter_if #(.WIDTH(8))  b0 ();
  sqrt_iter_if #(.WIDTH(8))  b1 ();
  sqrt_iter_if #(.WIDTH(16)) b2 ();

  assign b0.x_in    = x8;
  assign b0.x_ready = xr8;
  assign b1.x_in    = x8;
  assign b1.x_ready = xr8;
  assign b2.x_in    = x16;
  assign b2.x_ready = xr16;

  sqrt_iter #(.WIDTH(8),  .ROUND(0)) u_floor8 (.clk(clk), .rst(rst), .bus(b0));
  sqrt_iter #(.WIDTH(8),  .ROUND(1)) u_round8 (.clk(clk), .rst(rst), .bus(b1));
  sqrt_iter #(.WIDTH(16), .ROUND(0)) u_floor16 (.clk(clk), .rst(rst), .bus(b2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int froot(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int rroot(input int x, input int hw);
    int r = froot(x);
    if ((x - r * r) > r && r != (1 << hw) - 1) r++;
    return r;
  endfunction

  task automatic run8(input int x);
    int k;
    @(negedge clk);
    x8  = 8'(x);
    xr8 = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_cap8", b0.busy, 1);
    @(negedge clk);
    xr8 = 1'b0;
    x8  = 8'($urandom);
    for (k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (b0.y_ready) break;
      if (b0.busy !== 1'b1) chk("busy_mid8", b0.busy, 1);
    end
    chk("lat8", k, 5);
    chk("y_floor8", b0.y_out, froot(x));
    chk("r_floor8", b0.r_out, x - froot(x) * froot(x));
    chk("busy_done8", b0.busy, 0);
    chk("rdy_round8", b1.y_ready, 1);
    chk("y_round8", b1.y_out, rroot(x, 4));
    chk("r_round8", b1.r_out, x - froot(x) * froot(x));
    @(posedge clk);
    #1;
    chk("pulse_end8", b0.y_ready, 0);
    chk("y_hold8", b0.y_out, froot(x));
  endtask

  task automatic run16(input int x);
    int k;
    @(negedge clk);
    x16  = 16'(x);
    xr16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    xr16 = 1'b0;
    x16  = 16'($urandom);
    for (k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (b2.y_ready) break;
    end
    chk("lat16", k, 9);
    chk("y_floor16", b2.y_out, froot(x));
    chk("r_floor16", b2.r_out, x - froot(x) * froot(x));
    @(posedge clk);
    #1;
    chk("pulse_end16", b2.y_ready, 0);
  endtask

  initial begin
    int xv[30];
    rst  = 1'b1;
    x8   = '0;
    xr8  = 1'b0;
    x16  = '0;
    xr16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", b0.y_out, 0);
    chk("rst_r", b0.r_out, 0);
    chk("rst_rdy", b0.y_ready, 0);
    chk("rst_busy", b0.busy, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (xv[i]) xv[i] = 0;
    run8(0);
    run8(255);
    run8(144);
    run8(56);
    run8(57);
    repeat (20) run8(int'($urandom_range(255, 0)));

    // asynchronous reset between edges clears held results
    run8(255);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_y", b0.y_out, 0);
    chk("async_r", b0.r_out, 0);
    @(negedge clk);
    rst = 1'b0;

    // x_ready held high: only one capture per 6 cycles
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      x8    = 8'($urandom);
      xr8   = 1'b1;
      xv[t] = int'(x8);
      @(posedge clk);
      #1;
      chk("stream_rdy", b0.y_ready, (t % 6 == 5) ? 1 : 0);
      if (t % 6 == 5) begin
        chk("stream_y", b0.y_out, froot(xv[t-5]));
        chk("stream_r", b0.r_out, xv[t-5] - froot(xv[t-5]) * froot(xv[t-5]));
        chk("stream_yr", b1.y_out, rroot(xv[t-5], 4));
      end
    end
    @(negedge clk);
    xr8 = 1'b0;

    // abort two cycles into a computation
    @(negedge clk);
    x8  = 8'd200;
    xr8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    xr8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", b0.busy, 0);
    chk("abort_y", b0.y_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk);
      #1;
      if (b0.y_ready !== 1'b0) chk("abort_rdy", b0.y_ready, 0);
    end
    chk("abort_r", b0.r_out, 0);
    run8(100);

    run16(65535);
    run16(0);
    repeat (30) run16(int'($urandom_range(65535, 0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
